// File: rtl/rf_writeback_queue.sv
// Writeback queue between execute and the 3R/1W register file.
// Results are buffered in a small circular FIFO and drained one per cycle.
// Each operand-fetch read address is checked against all pending writes.
// Optional build macro RF_WBQ_FWD_EN: when defined, adds forwarding outputs that return
// the youngest pending value for each read address, and holds the hazard flags at 0.
module rf_writeback_queue #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  rf_hold,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  input  logic [ADDR_WIDTH-1:0] read_addr_3,
  output logic                  hazard_1,
  output logic                  hazard_2,
  output logic                  hazard_3,
`ifdef RF_WBQ_FWD_EN
  output logic                  fwd_valid_1,
  output logic                  fwd_valid_2,
  output logic                  fwd_valid_3,
  output logic [DATA_WIDTH-1:0] fwd_data_1,
  output logic [DATA_WIDTH-1:0] fwd_data_2,
  output logic [DATA_WIDTH-1:0] fwd_data_3,
`endif
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2-1:0] head_q, head_d;
  logic [DEPTH_LOG2-1:0] tail_q, tail_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] rd_addr [3];

  assign rd_addr[0] = read_addr_1;
  assign rd_addr[1] = read_addr_2;
  assign rd_addr[2] = read_addr_3;

  // Status and handshake; count never exceeds DEPTH, so its MSB alone marks full.
  always_comb begin
    empty      = (count_q == '0);
    full       = count_q[DEPTH_LOG2];
    in_ready   = !full && rst_n;
    write_en   = !empty && !rf_hold;
    write_addr = addr_q[head_q];
    write_data = data_q[head_q];
    count      = count_q;
    push       = in_valid && in_ready;
    pop        = write_en;
  end

  // Pointer, occupancy and valid-bit next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage; contents are meaningless unless the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_lookup
    logic                  hit;
    logic [DEPTH_LOG2-1:0] idx;
`ifdef RF_WBQ_FWD_EN
    logic [DATA_WIDTH-1:0] data;
`endif
    // Scan oldest to youngest so the last match wins as the youngest pending value.
    always_comb begin
      hit = 1'b0;
      idx = '0;
`ifdef RF_WBQ_FWD_EN
      data = '0;
`endif
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = head_q + DEPTH_LOG2'(i);
        if (valid_q[idx] && (addr_q[idx] == rd_addr[k])) begin
          hit = 1'b1;
`ifdef RF_WBQ_FWD_EN
          data = data_q[idx];
`endif
        end
      end
    end
  end

`ifdef RF_WBQ_FWD_EN
  // Consumer selects forwarded data, so no stall is signalled.
  always_comb begin
    hazard_1    = 1'b0;
    hazard_2    = 1'b0;
    hazard_3    = 1'b0;
    fwd_valid_1 = g_lookup[0].hit;
    fwd_valid_2 = g_lookup[1].hit;
    fwd_valid_3 = g_lookup[2].hit;
    fwd_data_1  = g_lookup[0].data;
    fwd_data_2  = g_lookup[1].data;
    fwd_data_3  = g_lookup[2].data;
  end
`else
  // Any pending write to a read address is a hazard.
  always_comb begin
    hazard_1 = g_lookup[0].hit;
    hazard_2 = g_lookup[1].hit;
    hazard_3 = g_lookup[2].hit;
  end
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Self-checking bench for rf_writeback_queue against a queue-based reference model.
module tb_rf_writeback_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [15:0] in_data;
  logic        rf_hold;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [15:0] write_data;
  logic [4:0]  read_addr_1, read_addr_2, read_addr_3;
  logic        hazard_1, hazard_2, hazard_3;
  logic [2:0]  count;
  logic        empty;
  logic        full;
`ifdef RF_WBQ_FWD_EN
  logic        fwd_valid_1, fwd_valid_2, fwd_valid_3;
  logic [15:0] fwd_data_1, fwd_data_2, fwd_data_3;
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: pending entries, oldest first, as {addr, data}.
  logic [20:0] mq [$];

  rf_writeback_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .rf_hold     (rf_hold),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_addr_1 (read_addr_1),
    .read_addr_2 (read_addr_2),
    .read_addr_3 (read_addr_3),
    .hazard_1    (hazard_1),
    .hazard_2    (hazard_2),
    .hazard_3    (hazard_3),
`ifdef RF_WBQ_FWD_EN
    .fwd_valid_1 (fwd_valid_1),
    .fwd_valid_2 (fwd_valid_2),
    .fwd_valid_3 (fwd_valid_3),
    .fwd_data_1  (fwd_data_1),
    .fwd_data_2  (fwd_data_2),
    .fwd_data_3  (fwd_data_3),
`endif
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit m_match(input logic [4:0] ra);
    foreach (mq[i]) if (mq[i][20:16] == ra) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] m_youngest(input logic [4:0] ra);
    logic [15:0] d;
    d = '0;
    foreach (mq[i]) if (mq[i][20:16] == ra) d = mq[i][15:0];
    return d;
  endfunction

  function automatic bit m_hazard(input logic [4:0] ra);
    return Fwd ? 1'b0 : m_match(ra);
  endfunction

  // Apply inputs mid-cycle and let combinational outputs settle.
  task automatic drive(input bit v, input logic [4:0] a, input logic [15:0] d,
                       input bit hold, input bit rst);
    @(negedge clk);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    rf_hold  = hold;
    rst_n    = rst;
    #1;
  endtask

  // Advance one rising edge and update the model from the rules.
  task automatic tick();
    bit pop, push;
    pop  = rst_n && (mq.size() > 0) && !rf_hold;
    push = rst_n && in_valid && (mq.size() < 4);
    @(posedge clk);
    if (!rst_n) mq.delete();
    else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({in_addr, in_data});
    end
  endtask

  task automatic test_reset();
    read_addr_1 = 5'd0; read_addr_2 = 5'd1; read_addr_3 = 5'd2;
    drive(1'b1, 5'd7, 16'h1234, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
    tick();
    drive(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL reset_write_en: got %b want 0", write_en); end
    n_cmp++; if ({hazard_1, hazard_2, hazard_3} !== 3'b000) begin n_fail++; $display("FAIL reset_hazard: got %b want 000", {hazard_1, hazard_2, hazard_3}); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    drive(1'b1, 5'd3, 16'h0003, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (write_en !== 1'b1) begin n_fail++; $display("FAIL single_write_en: got %b want 1", write_en); end
    n_cmp++; if (write_addr !== 5'd3) begin n_fail++; $display("FAIL single_addr: got %0d want 3", write_addr); end
    n_cmp++; if (write_data !== 16'h0003) begin n_fail++; $display("FAIL single_data: got %h want 0003", write_data); end
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count1: got %0d want 1", count); end
    tick();
    drive(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count0: got %0d want 0", count); end
  endtask

  task automatic test_full_hold();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 16'(i), 1'b1, 1'b1);
      tick();
    end
    drive(1'b1, 5'd5, 16'd5, 1'b1, 1'b1);
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL full_hold_write_en: got %b want 0", write_en); end
    tick();
    // Draining a full queue still refuses the push in the same cycle.
    for (int i = 1; i <= 4; i++) begin
      drive(i == 1, 5'd6, 16'd6, 1'b0, 1'b1);
      if (i == 1) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_drain_in_ready: got %b want 0", in_ready); end
      end
      n_cmp++; if (write_en !== 1'b1) begin n_fail++; $display("FAIL drain_we_%0d: got %b want 1", i, write_en); end
      n_cmp++; if (write_addr !== 5'(i)) begin n_fail++; $display("FAIL drain_addr_%0d: got %0d want %0d", i, write_addr, i); end
      n_cmp++; if (write_data !== 16'(i)) begin n_fail++; $display("FAIL drain_data_%0d: got %0d want %0d", i, write_data, i); end
      tick();
    end
    drive(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
    n_cmp++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL drain_idle_we: got %b want 0", write_en); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 16'(i), 1'b0, 1'b1);
      if (i > 0) begin
        n_cmp++; if (write_en !== 1'b1 || write_addr !== 5'(i - 1) || write_data !== 16'(i - 1)) begin
          n_fail++; $display("FAIL stream_%0d: got we=%b a=%0d d=%0d want we=1 a=%0d d=%0d", i, write_en, write_addr, write_data, i - 1, i - 1);
        end
      end
      n_cmp++; if (count !== 3'(mq.size()) || count > 3'd1) begin n_fail++; $display("FAIL stream_count_%0d: got %0d want %0d", i, count, mq.size()); end
      tick();
    end
    drive(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (write_en !== 1'b1 || write_addr !== 5'd31 || write_data !== 16'd31) begin
      n_fail++; $display("FAIL stream_last: got we=%b a=%0d d=%0d want we=1 a=31 d=31", write_en, write_addr, write_data);
    end
    tick();
  endtask

  task automatic test_hazard();
    drive(1'b1, 5'd5, 16'h0055, 1'b1, 1'b1); tick();
    drive(1'b1, 5'd9, 16'h0099, 1'b1, 1'b1); tick();
    read_addr_1 = 5'd5; read_addr_2 = 5'd9; read_addr_3 = 5'd7;
    drive(1'b0, 5'd0, 16'h0, 1'b1, 1'b1);
    n_cmp++; if ({hazard_1, hazard_2, hazard_3} !== (Fwd ? 3'b000 : 3'b110)) begin
      n_fail++; $display("FAIL hazard_held: got %b want %b", {hazard_1, hazard_2, hazard_3}, Fwd ? 3'b000 : 3'b110);
    end
    // The head entry being written this cycle still counts.
    drive(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (hazard_1 !== m_hazard(5'd5)) begin n_fail++; $display("FAIL hazard_head: got %b want %b", hazard_1, m_hazard(5'd5)); end
    tick();
    drive(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
    n_cmp++; if ({hazard_1, hazard_2} !== {1'b0, m_hazard(5'd9)}) begin
      n_fail++; $display("FAIL hazard_one_left: got %b want %b", {hazard_1, hazard_2}, {1'b0, m_hazard(5'd9)});
    end
    tick();
    drive(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
    n_cmp++; if ({hazard_1, hazard_2, hazard_3} !== 3'b000) begin n_fail++; $display("FAIL hazard_drained: got %b want 000", {hazard_1, hazard_2, hazard_3}); end
    // An in-flight push does not count.
    read_addr_1 = 5'd12;
    drive(1'b1, 5'd12, 16'h0C0C, 1'b0, 1'b1);
    n_cmp++; if (hazard_1 !== 1'b0) begin n_fail++; $display("FAIL hazard_inflight: got %b want 0", hazard_1); end
    tick();
    drive(1'b0, 5'd0, 16'h0, 1'b0, 1'b1); tick();
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(10 + i), 16'(100 + i), 1'b1, 1'b1); tick();
    end
    drive(1'b0, 5'd0, 16'h0, 1'b0, 1'b1); tick();
    read_addr_1 = 5'd10; read_addr_2 = 5'd11; read_addr_3 = 5'd12;
    drive(1'b0, 5'd0, 16'h0, 1'b1, 1'b0); tick();
    drive(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", count); end
    n_cmp++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_write_en: got %b want 0", write_en); end
    n_cmp++; if ({hazard_1, hazard_2, hazard_3} !== 3'b000) begin n_fail++; $display("FAIL rstmid_hazard: got %b want 000", {hazard_1, hazard_2, hazard_3}); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
      n_cmp++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale_%0d: got we=%b want 0", i, write_en); end
    end
  endtask

`ifdef RF_WBQ_FWD_EN
  task automatic test_fwd();
    drive(1'b1, 5'd6, 16'h00AA, 1'b1, 1'b1); tick();
    drive(1'b1, 5'd6, 16'h00BB, 1'b1, 1'b1); tick();
    read_addr_1 = 5'd6; read_addr_2 = 5'd7; read_addr_3 = 5'd6;
    drive(1'b0, 5'd0, 16'h0, 1'b1, 1'b1);
    n_cmp++; if (fwd_valid_1 !== 1'b1) begin n_fail++; $display("FAIL fwd_valid_1: got %b want 1", fwd_valid_1); end
    n_cmp++; if (fwd_data_1 !== 16'h00BB) begin n_fail++; $display("FAIL fwd_data_1: got %h want 00bb", fwd_data_1); end
    n_cmp++; if (hazard_1 !== 1'b0) begin n_fail++; $display("FAIL fwd_hazard_1: got %b want 0", hazard_1); end
    n_cmp++; if (fwd_valid_2 !== 1'b0) begin n_fail++; $display("FAIL fwd_valid_2: got %b want 0", fwd_valid_2); end
    drive(1'b0, 5'd0, 16'h0, 1'b1, 1'b0); tick();
  endtask
`endif

  task automatic test_random();
    bit v, h, r;
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 49) != 0);
      read_addr_1 = 5'($urandom_range(0, 7));
      read_addr_2 = 5'($urandom_range(0, 7));
      read_addr_3 = 5'($urandom_range(0, 7));
      drive(v, 5'($urandom_range(0, 7)), 16'($urandom), h, r);
      n_cmp++; if (count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, count, mq.size()); end
      n_cmp++; if (empty !== (mq.size() == 0) || full !== (mq.size() == 4)) begin
        n_fail++; $display("FAIL rnd_flags@%0d: got e=%b f=%b want e=%b f=%b", n, empty, full, mq.size() == 0, mq.size() == 4);
      end
      n_cmp++; if (in_ready !== (r && mq.size() < 4)) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %b want %b", n, in_ready, r && mq.size() < 4); end
      n_cmp++; if (write_en !== (mq.size() > 0 && !h)) begin n_fail++; $display("FAIL rnd_write_en@%0d: got %b want %b", n, write_en, mq.size() > 0 && !h); end
      if (mq.size() > 0) begin
        n_cmp++; if ({write_addr, write_data} !== mq[0]) begin n_fail++; $display("FAIL rnd_head@%0d: got %h want %h", n, {write_addr, write_data}, mq[0]); end
      end
      n_cmp++; if ({hazard_1, hazard_2, hazard_3} !== {m_hazard(read_addr_1), m_hazard(read_addr_2), m_hazard(read_addr_3)}) begin
        n_fail++; $display("FAIL rnd_hazard@%0d: got %b want %b", n, {hazard_1, hazard_2, hazard_3},
                           {m_hazard(read_addr_1), m_hazard(read_addr_2), m_hazard(read_addr_3)});
      end
`ifdef RF_WBQ_FWD_EN
      n_cmp++; if ({fwd_valid_1, fwd_valid_2, fwd_valid_3} !== {m_match(read_addr_1), m_match(read_addr_2), m_match(read_addr_3)}) begin
        n_fail++; $display("FAIL rnd_fwd_valid@%0d: got %b", n, {fwd_valid_1, fwd_valid_2, fwd_valid_3});
      end
      if (m_match(read_addr_1)) begin
        n_cmp++; if (fwd_data_1 !== m_youngest(read_addr_1)) begin n_fail++; $display("FAIL rnd_fwd_data_1@%0d: got %h want %h", n, fwd_data_1, m_youngest(read_addr_1)); end
      end
      if (m_match(read_addr_3)) begin
        n_cmp++; if (fwd_data_3 !== m_youngest(read_addr_3)) begin n_fail++; $display("FAIL rnd_fwd_data_3@%0d: got %h want %h", n, fwd_data_3, m_youngest(read_addr_3)); end
      end
`endif
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; rf_hold = 1'b0;
    read_addr_1 = '0; read_addr_2 = '0; read_addr_3 = '0;
    test_reset();
    test_single();
    test_full_hold();
    test_stream();
    test_hazard();
    test_reset_mid_drain();
`ifdef RF_WBQ_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
